// File: rtl/snn_pkg.sv
// snn_pkg: shared sizes and loader FSM states for the SNN digit classifier front end.
package snn_pkg;
  localparam int NUM_PIXELS    = 784;
  localparam int BYTE_W        = 8;
  localparam int BYTES_PER_IMG = NUM_PIXELS / BYTE_W;
  localparam int ADDR_W        = 10;
  localparam int BIT_W         = $clog2(BYTE_W);
  localparam int BYTE_CNT_W    = ADDR_W - BIT_W;
  typedef enum logic [2:0] {LOAD, UNPACK, CKSUM, START, RUN} loader_state_t;
endpackage

// File: rtl/ram_input_unit.sv
// ram_input_unit: 784x1 synchronous RAM with registered read; storage is never reset.
module ram_input_unit
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              data,
  input  logic [ADDR_W-1:0] addr,
  output logic              q
);
  logic mem [NUM_PIXELS];
  logic w_in_range;
  assign w_in_range = addr < ADDR_W'(NUM_PIXELS);
  always_ff @(posedge clk) begin
    if (we && w_in_range) mem[addr] <= data;
    q <= w_in_range ? mem[addr] : 1'b0;
  end
endmodule

// File: rtl/snn_image_loader.sv
// snn_image_loader: unpacks UART bytes into the input-unit RAM, starts the core, serves its reads.
// Define SNN_LOADER_CKSUM_EN to require a trailing XOR checksum byte after each image.
module snn_image_loader
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              clr_rx_rdy,
  input  logic [ADDR_W-1:0] addr_input_unit,
  output logic              q_input,
  output logic              start,
  input  logic              core_done,
  output logic              busy,
  output logic              img_err
);
`ifdef SNN_LOADER_CKSUM_EN
  localparam loader_state_t AFTER_IMG = CKSUM;
  logic [7:0] r_xor;
  logic       r_img_err;
  assign img_err = r_img_err;
`else
  localparam loader_state_t AFTER_IMG = START;
  assign img_err = 1'b0;
`endif
  loader_state_t         r_state;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [7:0]            r_shift;
  logic                  r_clr, r_start, r_busy, r_rd_ok;
  logic                  w_core_side, w_q;
  logic [ADDR_W-1:0]     w_addr;
  assign w_core_side = (r_state == START) || (r_state == RUN);
  assign w_addr      = w_core_side ? addr_input_unit : {r_byte_cnt, r_bit_cnt};
  assign clr_rx_rdy  = r_clr;
  assign start       = r_start;
  assign busy        = r_busy;
  // r_rd_ok masks the RAM output outside core reads and for out-of-range addresses
  assign q_input     = w_q & r_rd_ok;
  ram_input_unit u_ram (
    .clk  (clk),
    .we   (r_state == UNPACK),
    .data (r_shift[0]),
    .addr (w_addr),
    .q    (w_q)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LOAD;
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_clr      <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_ok    <= 1'b0;
`ifdef SNN_LOADER_CKSUM_EN
      r_xor      <= '0;
      r_img_err  <= 1'b0;
`endif
    end else begin
      r_clr   <= 1'b0;
      r_start <= 1'b0;
      r_rd_ok <= w_core_side && (addr_input_unit < ADDR_W'(NUM_PIXELS));
`ifdef SNN_LOADER_CKSUM_EN
      r_img_err <= 1'b0;
`endif
      case (r_state)
        LOAD: if (rx_rdy) begin
          r_shift <= rx_data;
          r_clr   <= 1'b1;
          r_state <= UNPACK;
`ifdef SNN_LOADER_CKSUM_EN
          r_xor   <= r_xor ^ rx_data;
`endif
        end
        UNPACK: begin
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == BIT_W'(BYTE_W - 1)) begin
            r_byte_cnt <= (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_IMG - 1)) ? '0 : r_byte_cnt + 1'b1;
            r_state    <= (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_IMG - 1)) ? AFTER_IMG : LOAD;
          end
        end
`ifdef SNN_LOADER_CKSUM_EN
        CKSUM: if (rx_rdy) begin
          r_clr     <= 1'b1;
          r_xor     <= '0;
          r_img_err <= rx_data != r_xor;
          r_state   <= (rx_data == r_xor) ? START : LOAD;
        end
`else
        CKSUM: r_state <= LOAD;
`endif
        START: begin
          r_start <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= RUN;
        end
        RUN: if (core_done) begin
          r_busy  <= 1'b0;
          r_state <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_image_loader.sv
// tb_snn_image_loader: directed image loads checked against a pixel-array model of the loader.
module tb_snn_image_loader;
  import snn_pkg::*;
`ifdef SNN_LOADER_CKSUM_EN
  localparam int START_LAT = 2;
  localparam int CK = 1;
`else
  localparam int START_LAT = 10;
  localparam int CK = 0;
`endif
  logic clk = 0, rst_n = 0, rx_rdy = 0, core_done = 0;
  logic [7:0] rx_data = 0;
  logic [9:0] addr = 0;
  logic clr_rx_rdy, q_input, start, busy, img_err;
  int n_cmp = 0, n_bad = 0, cyc = 0, start_cnt = 0, clr_cnt = 0, err_cnt = 0, start_cyc = 0;
  bit mdl_run = 0;
  bit mdl_px [1024];
  logic [7:0] img [BYTES_PER_IMG];

  always #5 clk = ~clk;

  snn_image_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
    .addr_input_unit(addr), .q_input(q_input), .start(start), .core_done(core_done),
    .busy(busy), .img_err(img_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor and per-cycle read comparison against the pixel model
  always @(posedge clk) begin
    #1;
    cyc++;
    if (start) begin start_cnt++; start_cyc = cyc; end
    if (clr_rx_rdy) clr_cnt++;
    if (img_err) err_cnt++;
    if (mdl_run) check("q_input_model", q_input, (addr < NUM_PIXELS) ? mdl_px[addr] : 1'b0);
  end

  task automatic send_byte(input logic [7:0] b, output int c0);
    @(negedge clk);
    rx_data = b; rx_rdy = 1; c0 = cyc;
    for (int i = 0; i < 30 && !clr_rx_rdy; i++) @(negedge clk);
    check("clr_rx_rdy_seen", clr_rx_rdy, 1);
    rx_rdy = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_image(input int first, input int bad_ck);
    int c0, s0, k0, e0;
    logic [7:0] x;
    s0 = start_cnt; k0 = clr_cnt; e0 = err_cnt; x = 0;
    for (int i = 0; i < BYTES_PER_IMG; i++) x ^= img[i];
    for (int i = first; i < BYTES_PER_IMG; i++) send_byte(img[i], c0);
`ifdef SNN_LOADER_CKSUM_EN
    send_byte(x ^ 8'(bad_ck), c0);
`endif
    repeat (START_LAT + 2) @(negedge clk);
    check("start_count", start_cnt - s0, bad_ck ? 0 : 1);
    check("clr_count", clr_cnt - k0, BYTES_PER_IMG - first + CK);
    check("img_err_count", err_cnt - e0, bad_ck);
    if (bad_ck == 0) begin
      check("start_latency", start_cyc - c0, START_LAT);
      check("busy_in_run", busy, 1);
      for (int i = 0; i < NUM_PIXELS; i++) mdl_px[i] = img[i / 8][i % 8];
      mdl_run = 1;
    end
  endtask

  task automatic finish_core();
    @(negedge clk);
    core_done = 1; mdl_run = 0;
    @(negedge clk);
    core_done = 0;
    check("busy_after_done", busy, 0);
  endtask

  task automatic read_lit(input string nm, input logic [9:0] a, input logic e);
    @(negedge clk);
    addr = a;
    @(posedge clk); #1;
    check(nm, q_input, e);
  endtask

  task automatic sweep();
    for (int a = 0; a < 800; a++) begin @(negedge clk); addr = 10'(a); end
    @(negedge clk); addr = 10'd1023;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {clr_rx_rdy, start, busy, img_err, q_input}, 0);
    rst_n = 1;
    @(negedge clk);
    check("post_reset_outputs", {clr_rx_rdy, start, busy, img_err, q_input}, 0);

    // Image A: every byte 01 -> pixel i set iff i%8 == 0
    for (int k = 0; k < BYTES_PER_IMG; k++) img[k] = 8'h01;
    send_image(0, 0);
    check("model_px0", mdl_px[0], 1);
    check("model_px1", mdl_px[1], 0);
    check("model_px8", mdl_px[8], 1);
    read_lit("read_a0", 10'd0, 1);
    read_lit("read_a1", 10'd1, 0);
    read_lit("read_a8", 10'd8, 1);
    sweep();

    // Image B arrives while the core still runs: its first byte must wait
    for (int k = 0; k < BYTES_PER_IMG; k++) img[k] = 8'(k * 37 + 11);
    img[BYTES_PER_IMG - 1] = 8'h80;
    @(negedge clk);
    rx_data = img[0]; rx_rdy = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("holdoff_clr_busy", {clr_rx_rdy, busy}, 2'b01);
    end
    core_done = 1; mdl_run = 0;
    @(negedge clk);
    core_done = 0;
    check("holdoff_busy_clear", {busy, clr_rx_rdy}, 2'b00);
    @(negedge clk);
    check("pending_consumed", clr_rx_rdy, 1);
    rx_rdy = 0;
    repeat (8) @(negedge clk);
    send_image(1, 0);
    check("model_px783", mdl_px[783], 1);
    read_lit("read_b783", 10'd783, 1);
    read_lit("read_b800", 10'd800, 0);
    read_lit("read_b782", 10'd782, 0);
    sweep();
    finish_core();

    // Reset mid-image, then a fresh image D must need all 98 bytes
    for (int k = 0; k < 40; k++) send_byte(8'hFF, c0);
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("reset_mid_outputs", {clr_rx_rdy, start, busy, img_err, q_input}, 0);
    rst_n = 1;
    for (int k = 0; k < BYTES_PER_IMG; k++) img[k] = 8'(k * 13) ^ 8'h3C;
    send_image(0, 0);
    read_lit("read_d0", 10'd0, 0);
    read_lit("read_d2", 10'd2, 1);
    sweep();
    finish_core();

`ifdef SNN_LOADER_CKSUM_EN
    for (int k = 0; k < BYTES_PER_IMG; k++) img[k] = 8'hA5;
    send_image(0, 0);
    read_lit("read_f0", 10'd0, 1);
    finish_core();
    send_image(0, 1);
    for (int k = 0; k < BYTES_PER_IMG; k++) img[k] = 8'(k);
    send_image(0, 0);
    sweep();
    finish_core();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snn_image_loader.md
Name: snn_image_loader

Overview:
Upstream stage of the SNN digit classifier. It receives a 28x28 binary image as packed bytes from the UART receiver and unpacks each byte into a 784x1 input-unit RAM. When the image is complete it pulses start to the SNN core, then serves the core's reads of q_input until the core reports done. It owns the input-unit RAM and is the only path by which pixels reach the core.

Parameters:
NUM_PIXELS, 784, pixel count per image; RAM depth.
BYTE_W, 8, pixels packed per received byte.
BYTES_PER_IMG, 98, NUM_PIXELS/BYTE_W; NUM_PIXELS must be an exact multiple of BYTE_W.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
rx_data  in  8  received byte from UART rx
rx_rdy  in  1  level; byte valid, held until cleared
clr_rx_rdy  out  1  1-cycle pulse; consumes rx_data
addr_input_unit  in  10  core read address
q_input  out  1  pixel at core address; 1-cycle read latency
start  out  1  1-cycle pulse to core; image loaded
core_done  in  1  1-cycle pulse from core; classification finished
busy  out  1  high from start pulse through core_done
img_err  out  1  1-cycle pulse; checksum failure (feature only)

Behaviour:
- Reset values: clr_rx_rdy=0, start=0, busy=0, img_err=0, q_input=0. FSM goes to LOAD; byte_cnt=0, bit_cnt=0. RAM contents are not reset.
- Bit order: pixel index = byte_cnt*8 + bit. rx_data[0] is the lowest pixel of each byte.
- LOAD state:
  - If rx_rdy=1, latch rx_data into shift_reg, pulse clr_rx_rdy in the same cycle, and go to UNPACK.
  - If rx_rdy=0, stay in LOAD.
- UNPACK state:
  - Runs 8 cycles. Each cycle writes shift_reg[0] to RAM[byte_cnt*8+bit_cnt], then shifts right and increments bit_cnt.
  - At bit_cnt=7: bit_cnt wraps to 0 and byte_cnt increments.
  - If byte_cnt was BYTES_PER_IMG-1, byte_cnt clears to 0 and the FSM goes to START. Otherwise it returns to LOAD.
- START state: one cycle; start=1 and busy is set. Next state is RUN.
- RUN state:
  - RAM address comes from addr_input_unit. q_input is registered and equals RAM[addr] one clock after addr is presented.
  - If addr >= NUM_PIXELS, q_input=0.
  - On core_done, clear busy and go to LOAD.
  - rx_rdy is ignored in RUN; the byte waits un-cleared.
- RAM address mux: write counter in LOAD/UNPACK; addr_input_unit in START/RUN. There are no writes in START/RUN.
- Simultaneous events:
  - core_done in the START cycle is ignored; only RUN samples it.
  - rx_rdy during UNPACK is ignored until the FSM returns to LOAD.
- Reset mid-operation: an asynchronous reset mid-image discards the partial image. The next byte received is byte 0.
- A UART byte takes far longer than 10 clocks, so no rx overrun handling is needed.

Optional Feature:
SNN_LOADER_CKSUM_EN
- Defined:
  - After byte BYTES_PER_IMG-1, the FSM enters CKSUM, which waits on rx_rdy for one extra byte and clears it.
  - That byte is compared with the XOR of all 98 image bytes, accumulated in LOAD.
  - Match: go to START.
  - Mismatch: img_err pulses for 1 cycle, no start, and the FSM returns to LOAD with byte_cnt=0.
  - The XOR accumulator clears on reset and at every image boundary.
- Undefined: no CKSUM state. img_err is tied to 0. START follows the 98th byte directly.

Decomposition:
- snn_pkg holds:
  - NUM_PIXELS, BYTE_W and BYTES_PER_IMG localparams.
  - loader_state_t enum: LOAD, UNPACK, CKSUM, START, RUN.
- Sub-module ram_input_unit: 784x1 synchronous RAM with ports data, addr[9:0], we, clk, q. q is registered; no reset on storage.
- FSM, counters and address mux live in snn_image_loader.

Test Plan:
- 98 bytes of 8'h01 -> clr_rx_rdy pulses once per byte. start pulses exactly once, 10 clocks after the last byte's rx_rdy. Reads: addr 0 gives q_input=1, addr 1 gives 0, addr 8 gives 1, each 1 cycle after addr.
- Full image then core_done held off 50 cycles while rx_rdy=1 -> clr_rx_rdy stays 0 and busy stays 1. Pulse core_done -> busy=0, and the pending byte is consumed on the next LOAD cycle.
- addr_input_unit=783 after an image whose last byte is 8'h80 -> q_input=1. addr=800 -> q_input=0.
- Assert rst_n low after 40 bytes, then send 98 new bytes -> start pulses after exactly 98 bytes. RAM reflects only the new image.
- SNN_LOADER_CKSUM_EN, 98 bytes 8'hA5 with checksum 8'h00 -> start pulses. Same image with checksum 8'h01 -> img_err pulses, no start, and the next byte is treated as byte 0.
- Back-to-back: two images with core_done between them -> two start pulses. The second image's reads return the second image's data.
